// File: rtl/stepper_seq.sv
// Stepper-motor phase sequencer: accepts a (direction, step count) move and walks a
// 4-coil drive table one entry per rising edge of step_clk. Optional STEPPER_HALF_STEP_EN.
module stepper_seq #(
  parameter int STEPS_W = 16,
  parameter bit HOLD    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_clk,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               stop,
  output logic [3:0]         coils,
  output logic               busy,
  output logic               done,
  output logic [STEPS_W-1:0] steps_left
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state, state_n;
  logic               step_d;
  logic               tick;
  logic               dir_q;
  logic [PH_W-1:0]    phase_q;
  logic [PH_W-1:0]    phase_n;
  logic [3:0]         coils_q;
  logic [STEPS_W-1:0] steps_q;
  logic               accept;
  logic               advance;

  function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] idx);
    logic [3:0] pat;
`ifdef STEPPER_HALF_STEP_EN
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
`else
    case (idx)
      2'd0:    pat = 4'b1100;
      2'd1:    pat = 4'b0110;
      2'd2:    pat = 4'b0011;
      default: pat = 4'b1001;
    endcase
`endif
    return pat;
  endfunction

  // Index arithmetic is modulo the table length, so wrap-around comes for free.
  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] idx,
                                                  input logic            fwd);
    return fwd ? idx + 1'b1 : idx - 1'b1;
  endfunction

  assign tick    = step_clk & ~step_d;
  assign phase_n = next_phase(phase_q, dir_q);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    advance = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && !reset) begin
          accept  = 1'b1;
          state_n = (cmd_steps == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        // An abort takes priority over a coincident step so the rotor does not move.
        if (stop) begin
          state_n = FIN;
        end else if (tick) begin
          advance = 1'b1;
          if (steps_q == STEPS_W'(1)) state_n = FIN;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      step_d  <= 1'b0;
      dir_q   <= 1'b0;
      phase_q <= '0;
      coils_q <= 4'b0000;
      steps_q <= '0;
    end else begin
      state  <= state_n;
      step_d <= step_clk;
      if (accept) begin
        dir_q   <= cmd_dir;
        steps_q <= cmd_steps;
      end
      if (advance) begin
        phase_q <= phase_n;
        coils_q <= phase_pattern(phase_n);
        steps_q <= steps_q - STEPS_W'(1);
      end
    end
  end

  assign cmd_ready  = (state == IDLE) && !reset;
  assign busy       = (state == RUN);
  assign done       = (state == FIN);
  // Without holding torque the coils are de-energised whenever no move is running.
  assign coils      = (HOLD || state == RUN) ? coils_q : 4'b0000;
  assign steps_left = steps_q;

endmodule

// File: doc/stepper_seq.md
# stepper_seq

Stepper-motor phase sequencer for the cube-turning actuators. It sits directly downstream of the frequency divider and consumes the divider's `clkout` square wave as its step-rate reference. It accepts a move command (direction + step count) over a valid/ready handshake. It then advances a 4-coil drive pattern by one phase on each rising edge of the step-rate signal, and reports completion with a one-cycle `done` pulse.

## Interface
- `STEPS_W`, 16, width of the step count and remaining-step counter
- `HOLD`, 1, 1 = coils keep last pattern while idle (holding torque); 0 = coils driven to 4'b0000 while idle
- `clk` input 1, system clock; all logic on rising edge
- `reset` input 1, synchronous, active-high; the only reset in the block
- `step_clk` input 1, divider `clkout`, synchronous to `clk`; each 0→1 transition is one step event
- `cmd_valid` input 1, command offered
- `cmd_ready` output 1, block can accept a command
- `cmd_dir` input 1, 1 = forward (phase index +1), 0 = reverse (phase index −1)
- `cmd_steps` input STEPS_W, number of phase advances to perform
- `stop` input 1, abort the current move
- `coils` output 4, coil drive pattern {A, B, C, D}
- `busy` output 1, move in progress
- `done` output 1, one-cycle pulse at end of a move (completed or aborted)
- `steps_left` output STEPS_W, remaining steps of the current or last move

## Operation
- **Step detection**
  - Register `step_d` holds the previous `step_clk` sample.
  - `tick = step_clk & ~step_d` (combinational).
  - `step_d` resets to 0.
- **FSM states:** IDLE, RUN, FIN.
- **IDLE**
  - `cmd_ready = 1` (forced 0 while `reset` is high).
  - On `cmd_valid & cmd_ready`, latch `cmd_dir`, load `steps_left <= cmd_steps`.
  - If `cmd_steps == 0`, go to FIN. Otherwise go to RUN.
- **RUN**
  - `busy = 1`, `cmd_ready = 0`. `cmd_valid` is ignored.
  - On `tick`:
    - Phase index advances by ±1 with wrap-around.
    - `coils` loads the table entry for the new index.
    - `steps_left` decrements.
    - When `steps_left` goes 1→0 on this tick, go to FIN.
  - On `stop` (checked before `tick`; `stop` wins over a simultaneous `tick`), go to FIN with no phase advance. `steps_left` keeps its current value.
- **FIN**
  - `done = 1` for exactly one cycle, `busy = 0`, then go to IDLE.
- **Phase tables**
  - Full-step, index 0..3: 1100, 0110, 0011, 1001.
  - Forward wraps 3→0; reverse wraps 0→3.
- **Idle coils**
  - With `HOLD = 1`, `coils` retains its last value.
  - With `HOLD = 0`, `coils = 0000` in IDLE and FIN.
  - The phase index is always retained, so the next move continues from the same rotor position.
- **`steps_left`** holds its value after the move; it is reloaded only on command acceptance.
- **Reset** (any state, mid-move included) forces:
  - state IDLE, phase index 0, `coils = 0000`, `busy = 0`, `done = 0`, `steps_left = 0`, `step_d = 0`.
  - Any in-flight move is discarded without a `done` pulse.

## Timing
- Command accept cycle N → `busy = 1` from cycle N+1.
- `tick` high in cycle T → new `coils` and decremented `steps_left` visible at T+1.
- Last step applied at T+1 → state FIN and `done = 1` at T+1, IDLE and `cmd_ready = 1` at T+2.
- Zero-step command accepted at N → `done` at N+1, `cmd_ready` at N+2, `coils` unchanged.
- A `step_clk` already high when RUN is entered produces no tick; only a later 0→1 transition counts.
- `stop` at cycle S → `done` at S+1.

## Configuration
- `STEPPER_HALF_STEP_EN` defined:
  - 8-entry half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
  - Index is 3 bits and wraps 7↔0.
  - Each tick is one half-step.
- `STEPPER_HALF_STEP_EN` not defined:
  - Full-step 4-entry table only.
  - Index is 2 bits.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-RUN with `steps_left = 5` → `coils = 0000`, `busy = 0`, `steps_left = 0`, no `done`, `cmd_ready = 0` during reset and 1 on the first cycle after.
- **Forward full-step:** `cmd_steps = 5`, `cmd_dir = 1`, from index 0 → `coils` 0110, 0011, 1001, 1100, 0110 on successive ticks; `done` one cycle after the 5th tick.
- **Reverse wrap:** from index 0, `cmd_steps = 2`, `cmd_dir = 0` → 1001 then 0011; `steps_left` 2→1→0.
- **Zero steps and busy guard:**
  - `cmd_steps = 0` → `done` at N+1, `busy` never 1.
  - `cmd_valid` held high during RUN → no second accept until `cmd_ready` returns.
- **Stop:** `stop` and `tick` in the same cycle with `steps_left = 7` → no coil change, `done` next cycle, `steps_left = 7`.
- **Half-step and hold:**
  - With `STEPPER_HALF_STEP_EN`, 8 forward ticks return `coils` to the pre-move pattern.
  - With `HOLD = 0`, `coils = 0000` after `done`.
